// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO family.
// Width helpers keep pointer/count sizing consistent between the top and its storage.
package fifo_pkg;

   localparam int FIFO_MODE_STD       = 0;
   localparam int FIFO_MODE_FWFT      = 1;
   localparam int FIFO_DEF_DATA_WIDTH = 32;
   localparam int FIFO_DEF_DEPTH      = 16;

   typedef enum logic [1:0] {
      FWFT_IDLE  = 2'd0,
      FWFT_FETCH = 2'd1,
      FWFT_VALID = 2'd2
   } fwft_state_t;

   function automatic int fifo_ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy has to reach DEPTH itself, hence depth+1 codes.
   function automatic int fifo_cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array with a registered read port.
// Contents are deliberately not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEF_DEPTH,
   parameter int PTR_WIDTH  = fifo_ptr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [PTR_WIDTH-1:0]  wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [PTR_WIDTH-1:0]  rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard (registered) or first-word-fall-through read,
// threshold flags and sticky overflow/underflow.
module sync_fifo_fwft
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = FIFO_DEF_DATA_WIDTH,
   parameter int DEPTH         = FIFO_DEF_DEPTH,
   parameter int PTR_WIDTH     = fifo_ptr_width(DEPTH),
   parameter int CNT_WIDTH     = fifo_cnt_width(DEPTH),
   parameter int FWFT          = FIFO_MODE_STD,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_WIDTH-1:0]  data_count,
   output logic [CNT_WIDTH-1:0]  free_count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_fwft: DEPTH must be at least 2");
   end
   if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $error("sync_fifo_fwft: AFULL_THRESH outside 0..DEPTH");
   end
   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
      $error("sync_fifo_fwft: AEMPTY_THRESH outside 0..DEPTH");
   end
   if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
      $error("sync_fifo_fwft: FWFT must be 0 or 1");
   end

   logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
   logic [CNT_WIDTH-1:0]  count, count_nxt, mem_count;
   logic                  push, pop, mem_rd, head_from_mem, std_loaded, bypass;
   logic [DATA_WIDTH-1:0] mem_q, out_reg;
   fwft_state_t           state;

   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
      return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + PTR_WIDTH'(1);
   endfunction

   assign push          = wr_en && !full;
   assign pop           = rd_en && !empty;
   assign head_from_mem = (state == FWFT_FETCH) && bypass;
   assign count_nxt     = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
   assign data_count    = count;

   // mem_count excludes the FWFT output stage; a word is only readable once it was written on an earlier edge.
   always_comb begin
      mem_rd = 1'b0;
      if (FWFT == FIFO_MODE_FWFT)
         mem_rd = (mem_count != '0) && ((state == FWFT_IDLE) || ((state == FWFT_VALID || head_from_mem) && pop));
      else
         mem_rd = pop;
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (mem_rd),
      .rd_addr (rd_ptr),
      .rd_data (mem_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         mem_count    <= '0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         free_count   <= CNT_WIDTH'(DEPTH);
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (push)   wr_ptr <= ptr_inc(wr_ptr);
         if (mem_rd) rd_ptr <= ptr_inc(rd_ptr);
         count        <= count_nxt;
         mem_count    <= mem_count + CNT_WIDTH'(push) - CNT_WIDTH'(mem_rd);
         full         <= (count_nxt == CNT_WIDTH'(DEPTH));
         almost_full  <= (count_nxt >= CNT_WIDTH'(AFULL_THRESH));
         almost_empty <= (count_nxt <= CNT_WIDTH'(AEMPTY_THRESH));
         free_count   <= CNT_WIDTH'(DEPTH) - count_nxt;
         overflow     <= (wr_en && full) || (overflow && !err_clr);
         underflow    <= (rd_en && empty) || (underflow && !err_clr);
      end
   end

   // state | meaning
   // IDLE  | output stage empty, no read outstanding
   // FETCH | memory read issued; with bypass set, mem_q already is the visible head
   // VALID | out_reg holds the head word
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FWFT_IDLE;
         bypass     <= 1'b0;
         out_reg    <= '0;
         empty      <= 1'b1;
         rd_valid   <= 1'b0;
         std_loaded <= 1'b0;
      end else if (FWFT == FIFO_MODE_FWFT) begin
         case (state)
            FWFT_IDLE: begin
               if (mem_count != '0) begin
                  state  <= FWFT_FETCH;
                  bypass <= 1'b0;
               end
            end
            FWFT_FETCH: begin
               if (bypass && pop) begin
                  state    <= mem_rd ? FWFT_FETCH : FWFT_IDLE;
                  bypass   <= mem_rd;
                  empty    <= !mem_rd;
                  rd_valid <= mem_rd;
               end else begin
                  state    <= FWFT_VALID;
                  bypass   <= 1'b0;
                  out_reg  <= mem_q;
                  empty    <= 1'b0;
                  rd_valid <= 1'b1;
               end
            end
            FWFT_VALID: begin
               if (pop) begin
                  state    <= mem_rd ? FWFT_FETCH : FWFT_IDLE;
                  bypass   <= mem_rd;
                  empty    <= !mem_rd;
                  rd_valid <= mem_rd;
               end
            end
            default: begin
               state    <= FWFT_IDLE;
               bypass   <= 1'b0;
               empty    <= 1'b1;
               rd_valid <= 1'b0;
            end
         endcase
      end else begin
         rd_valid <= pop;
         empty    <= (count_nxt == '0);
         if (pop) std_loaded <= 1'b1;
      end
   end

   // Standard mode shows zero until the first pop after reset, then holds the last popped word.
   assign rd_data = (FWFT == FIFO_MODE_FWFT) ? (head_from_mem ? mem_q : out_reg)
                                             : (std_loaded ? mem_q : '0);

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench: a standard DEPTH=8 instance driven from a vector table,
// a DEPTH=6 standard and a DEPTH=8 FWFT instance checked against queue models.
module tb_sync_fifo_fwft;
   import fifo_pkg::*;

   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic          s8_wr_en, s8_rd_en, s8_err_clr, s8_rd_valid, s8_full, s8_empty, s8_af, s8_ae, s8_ovf, s8_unf;
   logic [DW-1:0] s8_wr_data, s8_rd_data;
   logic [3:0]    s8_count, s8_free;

   logic          s6_wr_en, s6_rd_en, s6_err_clr, s6_rd_valid, s6_full, s6_empty, s6_af, s6_ae, s6_ovf, s6_unf;
   logic [DW-1:0] s6_wr_data, s6_rd_data;
   logic [2:0]    s6_count, s6_free;

   logic          fw_wr_en, fw_rd_en, fw_err_clr, fw_rd_valid, fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_unf;
   logic [DW-1:0] fw_wr_data, fw_rd_data;
   logic [3:0]    fw_count, fw_free;

   sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(8), .FWFT(FIFO_MODE_STD)) u_s8 (
      .clk(clk), .rst(rst), .wr_en(s8_wr_en), .wr_data(s8_wr_data), .rd_en(s8_rd_en),
      .rd_data(s8_rd_data), .rd_valid(s8_rd_valid), .full(s8_full), .empty(s8_empty),
      .almost_full(s8_af), .almost_empty(s8_ae), .data_count(s8_count), .free_count(s8_free),
      .overflow(s8_ovf), .underflow(s8_unf), .err_clr(s8_err_clr));

   sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(6), .FWFT(FIFO_MODE_STD)) u_s6 (
      .clk(clk), .rst(rst), .wr_en(s6_wr_en), .wr_data(s6_wr_data), .rd_en(s6_rd_en),
      .rd_data(s6_rd_data), .rd_valid(s6_rd_valid), .full(s6_full), .empty(s6_empty),
      .almost_full(s6_af), .almost_empty(s6_ae), .data_count(s6_count), .free_count(s6_free),
      .overflow(s6_ovf), .underflow(s6_unf), .err_clr(s6_err_clr));

   sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(8), .FWFT(FIFO_MODE_FWFT)) u_fw (
      .clk(clk), .rst(rst), .wr_en(fw_wr_en), .wr_data(fw_wr_data), .rd_en(fw_rd_en),
      .rd_data(fw_rd_data), .rd_valid(fw_rd_valid), .full(fw_full), .empty(fw_empty),
      .almost_full(fw_af), .almost_empty(fw_ae), .data_count(fw_count), .free_count(fw_free),
      .overflow(fw_ovf), .underflow(fw_unf), .err_clr(fw_err_clr));

   typedef struct {
      logic          wr_en;
      logic [DW-1:0] wr_data;
      logic          rd_en;
      logic          err_clr;
      logic          rd_valid;
      logic [DW-1:0] rd_data;
      int            count;
      logic          ovf;
      logic          unf;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic we, input logic [DW-1:0] wd, input logic re, input logic clr,
                               input logic rv, input logic [DW-1:0] rdd, input int cnt,
                               input logic ovf, input logic unf);
      vec_t v;
      v.wr_en = we; v.wr_data = wd; v.rd_en = re; v.err_clr = clr;
      v.rd_valid = rv; v.rd_data = rdd; v.count = cnt; v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_s8_flags(input string tag, input int cnt);
      chk({tag, ".count"}, 32'(s8_count), 32'(cnt));
      chk({tag, ".free"},  32'(s8_free), 32'(8 - cnt));
      chk({tag, ".full"},  32'(s8_full), 32'(cnt == 8));
      chk({tag, ".empty"}, 32'(s8_empty), 32'(cnt == 0));
      chk({tag, ".afull"}, 32'(s8_af), 32'(cnt >= 6));
      chk({tag, ".aempty"}, 32'(s8_ae), 32'(cnt <= 2));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int            q6[$];
      int            qf[$];
      int            last6, stall, exp_d;
      logic          e_ovf6, e_unf6, we, re, clr, push_ok, pop_ok;
      logic [DW-1:0] wd;

      rst = 1'b1;
      {s8_wr_en, s8_rd_en, s8_err_clr, s6_wr_en, s6_rd_en, s6_err_clr, fw_wr_en, fw_rd_en, fw_err_clr} = '0;
      s8_wr_data = '0; s6_wr_data = '0; fw_wr_data = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // reset state
      chk_s8_flags("rst.s8", 0);
      chk("rst.s8.rd_valid", 32'(s8_rd_valid), 0);
      chk("rst.s8.rd_data",  32'(s8_rd_data), 0);
      chk("rst.s8.ovf",      32'(s8_ovf), 0);
      chk("rst.s8.unf",      32'(s8_unf), 0);
      chk("rst.fw.empty",    32'(fw_empty), 1);
      chk("rst.fw.rd_valid", 32'(fw_rd_valid), 0);
      chk("rst.fw.free",     32'(fw_free), 8);

      // table: fill, overflow, drain, underflow, clear, set-beats-clear, no pass-through
      for (int i = 0; i < 8; i++) vt.push_back(mk(1, DW'(8'h10 + i), 0, 0, 0, 8'h00, i + 1, 0, 0));
      vt.push_back(mk(1, 8'hFF, 0, 0, 0, 8'h00, 8, 1, 0));
      for (int k = 0; k < 8; k++) vt.push_back(mk(0, 8'h00, 1, 0, 1, DW'(8'h10 + k), 7 - k, 1, 0));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h17, 0, 1, 1));
      vt.push_back(mk(0, 8'h00, 0, 1, 0, 8'h17, 0, 0, 0));
      vt.push_back(mk(0, 8'h00, 1, 1, 0, 8'h17, 0, 0, 1));
      vt.push_back(mk(1, 8'h55, 1, 0, 0, 8'h17, 1, 0, 1));
      vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h55, 0, 0, 1));

      foreach (vt[i]) begin
         s8_wr_en = vt[i].wr_en; s8_wr_data = vt[i].wr_data;
         s8_rd_en = vt[i].rd_en; s8_err_clr = vt[i].err_clr;
         tick();
         chk_s8_flags($sformatf("v%0d", i), vt[i].count);
         chk($sformatf("v%0d.rd_valid", i), 32'(s8_rd_valid), 32'(vt[i].rd_valid));
         chk($sformatf("v%0d.rd_data", i),  32'(s8_rd_data), 32'(vt[i].rd_data));
         chk($sformatf("v%0d.ovf", i),      32'(s8_ovf), 32'(vt[i].ovf));
         chk($sformatf("v%0d.unf", i),      32'(s8_unf), 32'(vt[i].unf));
      end
      {s8_wr_en, s8_rd_en, s8_err_clr} = '0;

      // FWFT: single word becomes visible two edges after the push edge
      fw_wr_en = 1'b1; fw_wr_data = 8'hA5;
      tick();
      fw_wr_en = 1'b0;
      chk("fw1.empty_e0", 32'(fw_empty), 1);
      tick();
      chk("fw1.empty_e1", 32'(fw_empty), 1);
      tick();
      chk("fw1.empty_e2", 32'(fw_empty), 0);
      chk("fw1.rd_data",  32'(fw_rd_data), 32'h A5);
      chk("fw1.rd_valid", 32'(fw_rd_valid), 1);
      chk("fw1.count",    32'(fw_count), 1);
      fw_rd_en = 1'b1;
      tick();
      fw_rd_en = 1'b0;
      chk("fw1.empty_pop", 32'(fw_empty), 1);
      chk("fw1.count_pop", 32'(fw_count), 0);

      // FWFT: four queued words drain one per cycle
      for (int k = 0; k < 4; k++) begin
         fw_wr_en = 1'b1; fw_wr_data = DW'(8'h31 + k);
         tick();
      end
      fw_wr_en = 1'b0;
      for (int t = 0; t < 6 && fw_empty; t++) tick();
      chk("fw4.ready", 32'(fw_empty), 0);
      chk("fw4.count", 32'(fw_count), 4);
      fw_rd_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fw4.empty%0d", k), 32'(fw_empty), 0);
         chk($sformatf("fw4.data%0d", k),  32'(fw_rd_data), 32'(8'h31 + k));
         tick();
      end
      fw_rd_en = 1'b0;
      chk("fw4.empty_end", 32'(fw_empty), 1);
      chk("fw4.count_end", 32'(fw_count), 0);

      // DEPTH=6 random traffic against a queue model; many wraps of both pointers
      e_ovf6 = 1'b0; e_unf6 = 1'b0; last6 = 0;
      for (int c = 0; c < 240; c++) begin
         we  = ($urandom_range(0, 99) < (((c / 30) % 2) ? 30 : 75));
         re  = ($urandom_range(0, 99) < 50);
         clr = ($urandom_range(0, 99) < 6);
         wd  = DW'($urandom);
         push_ok = we && (q6.size() < 6);
         pop_ok  = re && (q6.size() > 0);
         e_ovf6  = (we && q6.size() == 6) || (e_ovf6 && !clr);
         e_unf6  = (re && q6.size() == 0) || (e_unf6 && !clr);
         if (pop_ok) last6 = q6.pop_front();
         if (push_ok) q6.push_back(int'(wd));
         s6_wr_en = we; s6_wr_data = wd; s6_rd_en = re; s6_err_clr = clr;
         tick();
         chk($sformatf("s6c%0d.count", c),    32'(s6_count), 32'(q6.size()));
         chk($sformatf("s6c%0d.free", c),     32'(s6_free), 32'(6 - q6.size()));
         chk($sformatf("s6c%0d.full", c),     32'(s6_full), 32'(q6.size() == 6));
         chk($sformatf("s6c%0d.empty", c),    32'(s6_empty), 32'(q6.size() == 0));
         chk($sformatf("s6c%0d.afull", c),    32'(s6_af), 32'(q6.size() >= 4));
         chk($sformatf("s6c%0d.aempty", c),   32'(s6_ae), 32'(q6.size() <= 2));
         chk($sformatf("s6c%0d.rd_valid", c), 32'(s6_rd_valid), 32'(pop_ok));
         chk($sformatf("s6c%0d.rd_data", c),  32'(s6_rd_data), 32'(last6));
         chk($sformatf("s6c%0d.ovf", c),      32'(s6_ovf), 32'(e_ovf6));
         chk($sformatf("s6c%0d.unf", c),      32'(s6_unf), 32'(e_unf6));
      end
      {s6_wr_en, s6_rd_en, s6_err_clr} = '0;

      // FWFT random traffic: visible head must be the oldest word, count tracks the model
      stall = 0;
      for (int c = 0; c < 240; c++) begin
         we = ($urandom_range(0, 99) < (((c / 25) % 2) ? 35 : 70));
         re = ($urandom_range(0, 99) < 55);
         wd = DW'($urandom);
         if (!fw_empty) begin
            chk($sformatf("fwc%0d.has_head", c), 32'(q6.size() >= 0 && qf.size() > 0), 1);
            exp_d = (qf.size() > 0) ? qf[0] : -1;
            chk($sformatf("fwc%0d.head", c), 32'(fw_rd_data), 32'(exp_d));
         end
         stall = (qf.size() > 0 && fw_empty) ? stall + 1 : 0;
         chk($sformatf("fwc%0d.latency", c), 32'(stall > 3), 0);
         push_ok = we && (qf.size() < 8);
         pop_ok  = re && !fw_empty;
         if (pop_ok && qf.size() > 0) void'(qf.pop_front());
         if (push_ok) qf.push_back(int'(wd));
         fw_wr_en = we; fw_wr_data = wd; fw_rd_en = re;
         tick();
         chk($sformatf("fwc%0d.count", c), 32'(fw_count), 32'(qf.size()));
         chk($sformatf("fwc%0d.full", c),  32'(fw_full), 32'(qf.size() == 8));
      end
      {fw_wr_en, fw_rd_en} = '0;

      // reset in the middle of traffic with five words held and an error flag set
      for (int k = 0; k < 5; k++) begin
         s8_wr_en = 1'b1; s8_wr_data = DW'(8'h60 + k);
         tick();
      end
      chk_s8_flags("pre_rst", 5);
      chk("pre_rst.unf", 32'(s8_unf), 1);
      s8_rd_en = 1'b1;
      rst = 1'b1;
      tick();
      chk_s8_flags("mid_rst", 0);
      chk("mid_rst.ovf",      32'(s8_ovf), 0);
      chk("mid_rst.unf",      32'(s8_unf), 0);
      chk("mid_rst.rd_valid", 32'(s8_rd_valid), 0);
      chk("mid_rst.rd_data",  32'(s8_rd_data), 0);
      rst = 1'b0;
      {s8_wr_en, s8_rd_en} = '0;
      tick();
      chk_s8_flags("post_rst", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
